mma_mem_sequencer: RTL

Sequences one N×N matrix job over the three-port row RAM (read ports A/B, write port C). It streams N rows of operand A and N rows of operand B into the compute array, then collects N result rows and writes them back through port C. It sits between the accelerator's job-control logic (start/done) and the RAM, and is the only master of the RAM address, enable and write-enable lines.

---
 rtl/mma_mem_sequencer_if.sv | 46 ++++
 rtl/mma_mem_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mma_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mma_mem_sequencer_if
// Brief    : Job-control, compute-array and row-RAM signals of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mma_mem_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int ROW_BYTES  = 8,
  parameter int N          = 8
);
  localparam int c_IDX_W = $clog2(N);

  logic                    start_i;
  logic [ADDR_WIDTH-1:0]   base_a_i;
  logic [ADDR_WIDTH-1:0]   base_b_i;
  logic [ADDR_WIDTH-1:0]   base_c_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    array_ready_i;
  logic                    feed_valid_o;
  logic [c_IDX_W-1:0]      feed_idx_o;
  logic                    res_valid_i;
  logic [ROW_BYTES*8-1:0]  res_data_i;
  logic [ADDR_WIDTH-1:0]   addr_a_o;
  logic [ADDR_WIDTH-1:0]   addr_b_o;
  logic [ADDR_WIDTH-1:0]   addr_c_o;
  logic                    en_a_o;
  logic                    en_b_o;
  logic                    we_c_o;
  logic [ROW_BYTES*8-1:0]  wdata_c_o;
  logic [31:0]             cycles_o;

  modport master (
    input  start_i, base_a_i, base_b_i, base_c_i, array_ready_i, res_valid_i, res_data_i,
    output busy_o, done_o, feed_valid_o, feed_idx_o, addr_a_o, addr_b_o, addr_c_o,
           en_a_o, en_b_o, we_c_o, wdata_c_o, cycles_o
  );

  modport slave (
    output start_i, base_a_i, base_b_i, base_c_i, array_ready_i, res_valid_i, res_data_i,
    input  busy_o, done_o, feed_valid_o, feed_idx_o, addr_a_o, addr_b_o, addr_c_o,
           en_a_o, en_b_o, we_c_o, wdata_c_o, cycles_o
  );
endinterface
`default_nettype wire

// File: rtl/mma_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mma_mem_sequencer
// Brief    : Streams N A/B row pairs into the compute array and writes N result
//            rows back through port C. Define MMA_SEQ_PERF_EN for cycles_o.
// Revision : 1.0 - initial release
// ============================================================================
module mma_mem_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int ROW_BYTES  = 8,
  parameter int N          = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mma_mem_sequencer_if.master bus
);

  localparam int c_CNT_W     = $clog2(N) + 1;
  localparam int c_IDX_W     = $clog2(N);
  localparam int c_ROW_SHIFT = $clog2(ROW_BYTES);
  localparam logic [c_CNT_W-1:0] c_N_CNT    = c_CNT_W'(N);
  localparam logic [c_CNT_W-1:0] c_LAST_ROW = c_CNT_W'(N - 1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_FETCH   = 2'd1;
  localparam logic [1:0] c_ST_COLLECT = 2'd2;
  localparam logic [1:0] c_ST_DONE    = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_CNT_W-1:0]     r_rf;
  logic [c_CNT_W-1:0]     r_wc;
  logic [ADDR_WIDTH-1:0]  r_base_a;
  logic [ADDR_WIDTH-1:0]  r_base_b;
  logic [ADDR_WIDTH-1:0]  r_base_c;
  logic [ADDR_WIDTH-1:0]  r_addr_c;
  logic                   r_feed_valid;
  logic [c_IDX_W-1:0]     r_feed_idx;
  logic                   r_we_c;
  logic [ROW_BYTES*8-1:0] r_wdata_c;
  logic                   w_start;
  logic                   w_active;
  logic                   w_fire;
  logic                   w_accept;

  // Row stride is a power of two, so the row offset is a shift; wrap is modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [c_CNT_W-1:0]    row);
    return base + (ADDR_WIDTH'(row) << c_ROW_SHIFT);
  endfunction

  assign w_start  = (r_state == c_ST_IDLE) && bus.start_i;
  assign w_active = (r_state == c_ST_FETCH) || (r_state == c_ST_COLLECT);
  assign w_fire   = (r_state == c_ST_FETCH) && bus.array_ready_i;
  assign w_accept = w_active && bus.res_valid_i && (r_wc != c_N_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= c_ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (w_start) w_state_nxt = c_ST_FETCH;
      c_ST_FETCH:   if (w_fire && (r_rf == c_LAST_ROW)) w_state_nxt = c_ST_COLLECT;
      c_ST_COLLECT: if ((r_rf == c_N_CNT) && (r_wc == c_N_CNT)) w_state_nxt = c_ST_DONE;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Read enables are combinational so the RAM samples the request in the ready cycle.
  always_comb begin
    bus.busy_o   = w_active;
    bus.done_o   = (r_state == c_ST_DONE);
    bus.en_a_o   = w_fire;
    bus.en_b_o   = w_fire;
    bus.addr_a_o = row_addr(r_base_a, r_rf);
    bus.addr_b_o = row_addr(r_base_b, r_rf);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base_a     <= '0;
      r_base_b     <= '0;
      r_base_c     <= '0;
      r_rf         <= '0;
      r_wc         <= '0;
      r_feed_valid <= 1'b0;
      r_feed_idx   <= '0;
      r_we_c       <= 1'b0;
      r_addr_c     <= '0;
      r_wdata_c    <= '0;
    end else begin
      r_feed_valid <= w_fire;
      r_we_c       <= w_accept;
      if (w_start) begin
        r_base_a <= bus.base_a_i;
        r_base_b <= bus.base_b_i;
        r_base_c <= bus.base_c_i;
        r_rf     <= '0;
        r_wc     <= '0;
      end
      if (w_fire) begin
        r_rf       <= r_rf + c_CNT_W'(1);
        r_feed_idx <= r_rf[c_IDX_W-1:0];
      end
      if (w_accept) begin
        r_addr_c  <= row_addr(r_base_c, r_wc);
        r_wdata_c <= bus.res_data_i;
        r_wc      <= r_wc + c_CNT_W'(1);
      end
    end
  end

  assign bus.feed_valid_o = r_feed_valid;
  assign bus.feed_idx_o   = r_feed_idx;
  assign bus.we_c_o       = r_we_c;
  assign bus.addr_c_o     = r_addr_c;
  assign bus.wdata_c_o    = r_wdata_c;

`ifdef MMA_SEQ_PERF_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_cycles <= '0;
    else if (w_start)  r_cycles <= '0;
    else if (w_active) r_cycles <= r_cycles + 32'd1;
  end

  assign bus.cycles_o = r_cycles;
`else
  assign bus.cycles_o = '0;
`endif

endmodule
`default_nettype wire
